// File: rtl/game_state_engine_if.sv
// Frame-rate control inputs and registered object positions shared between the
// game state engine and its neighbours.
//   master: drives frame_tick/flap/start, observes positions, score and game_over
//   slave : the engine itself
interface game_state_engine_if;
  logic       frame_tick;
  logic       flap;
  logic       start;
  logic [9:0] plane_y;
  logic [9:0] mountain1_x;
  logic [9:0] mountain1_y;
  logic [9:0] mountain2_x;
  logic [9:0] mountain2_y;
  logic [9:0] lava_x;
  logic [9:0] lava_y;
  logic       game_over;
  logic [7:0] score;

  modport master (
    output frame_tick, flap, start,
    input  plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
    input  lava_x, lava_y, game_over, score
  );

  modport slave (
    input  frame_tick, flap, start,
    output plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
    output lava_x, lava_y, game_over, score
  );
endinterface

// File: rtl/game_state_engine.sv
// Per-frame game logic for the volcano flight game: plane height, two scrolling
// mountains, one lava bomb, collision detection and score.
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   gs     - slave side of game_state_engine_if (frame_tick/flap/start in;
//            plane_y, mountain1/2 x/y, lava x/y, score, game_over out)
module game_state_engine #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned PLANE_X    = 100,
  parameter int unsigned GRAVITY    = 2,
  parameter int unsigned LIFT       = 3,
  parameter int unsigned SCROLL     = 2,
  parameter int unsigned LAVA_SPEED = 4,
  parameter int unsigned MIN_TOP    = 240
) (
  input logic                clk,
  input logic                resetn,
  game_state_engine_if.slave gs
);

  localparam logic [9:0] ScrW      = 10'(SCREEN_W);
  localparam logic [9:0] Floor     = 10'(SCREEN_H - 17);
  localparam logic [9:0] Bottom    = 10'(SCREEN_H - 1);
  localparam logic [9:0] PlaneX    = 10'(PLANE_X);
  localparam logic [9:0] Gravity   = 10'(GRAVITY);
  localparam logic [9:0] Lift      = 10'(LIFT);
  localparam logic [9:0] Scroll    = 10'(SCROLL);
  localparam logic [9:0] LavaSpeed = 10'(LAVA_SPEED);
  localparam logic [9:0] MinTop    = 10'(MIN_TOP);
  localparam logic [9:0] ObjSz     = 10'd16;  // plane and lava box extent
  localparam logic [9:0] MtnW      = 10'd30;
  localparam logic [9:0] LavaOffX  = 10'd7;

  localparam logic [9:0]  RstPy   = 10'd200;
  localparam logic [9:0]  RstM1x  = 10'd640;
  localparam logic [9:0]  RstM1y  = 10'd300;
  localparam logic [9:0]  RstM2x  = 10'd960;
  localparam logic [9:0]  RstM2y  = 10'd350;
  localparam logic [9:0]  RstLx   = 10'd647;
  localparam logic [9:0]  RstLy   = 10'd284;
  localparam logic [15:0] RstLfsr = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  state_e      state_q, state_d;
  logic [9:0]  py_q, py_d, m1x_q, m1x_d, m1y_q, m1y_d, m2x_q, m2x_d, m2y_q, m2y_d;
  logic [9:0]  lx_q, lx_d, ly_q, ly_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        chk_q, chk_d;  // registered values are fresh from an update

  logic [9:0] up_py, up_m1x, up_m1y, up_m2x, up_m2y, up_lx, up_ly, new_top;
  logic [7:0] up_score;
  logic [8:0] score_sum;
  logic       m1_wrap, m2_wrap, hit, do_load, do_update;

  // Candidate next-frame values, derived from the current registers.
  always_comb begin
    new_top = MinTop + {3'b000, lfsr_q[6:0]};
    if (gs.flap) begin
      up_py = (py_q < Lift) ? '0 : py_q - Lift;
    end else begin
      up_py = (py_q > Floor - Gravity) ? Floor : py_q + Gravity;
    end
    m1_wrap = m1x_q < Scroll;
    m2_wrap = m2x_q < Scroll;
    // Wrapping by SCREEN_W - SCROLL keeps the two mountains evenly spaced.
    up_m1x = m1_wrap ? m1x_q + (ScrW - Scroll) : m1x_q - Scroll;
    up_m2x = m2_wrap ? m2x_q + (ScrW - Scroll) : m2x_q - Scroll;
    up_m1y = m1_wrap ? new_top : m1y_q;
    up_m2y = m2_wrap ? new_top : m2y_q;
    up_lx  = up_m1x + LavaOffX;
    up_ly  = (m1_wrap || ly_q < LavaSpeed) ? up_m1y - ObjSz : ly_q - LavaSpeed;
    score_sum = {1'b0, score_q} + {8'd0, m1_wrap} + {8'd0, m2_wrap};
    up_score  = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Inclusive-bound box overlap against the registered positions.
  always_comb begin
    logic hit_m1, hit_m2, hit_lava;
    hit_m1 = (m1x_q <= PlaneX + ObjSz) && (PlaneX <= m1x_q + MtnW) &&
             (m1y_q <= py_q + ObjSz) && (py_q <= Bottom);
    hit_m2 = (m2x_q <= PlaneX + ObjSz) && (PlaneX <= m2x_q + MtnW) &&
             (m2y_q <= py_q + ObjSz) && (py_q <= Bottom);
    hit_lava = (lx_q <= PlaneX + ObjSz) && (PlaneX <= lx_q + ObjSz) &&
               (ly_q <= py_q + ObjSz) && (py_q <= ly_q + ObjSz);
    hit = hit_m1 || hit_m2 || hit_lava || (py_q == Floor);
  end

  always_comb begin
    state_d   = state_q;
    py_d      = py_q;
    m1x_d     = m1x_q;
    m1y_d     = m1y_q;
    m2x_d     = m2x_q;
    m2y_d     = m2y_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    score_d   = score_q;
    chk_d     = 1'b0;
    do_load   = 1'b0;
    do_update = 1'b0;
    // Fibonacci taps 16,14,13,11, shifting right; free-running in every state.
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      StIdle: begin
        if (gs.start) begin
          do_load = 1'b1;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (chk_q && hit) begin
          state_d = StOver;
        end else if (gs.frame_tick) begin
          do_update = 1'b1;
          chk_d     = 1'b1;
        end
      end
      StOver: begin
        if (gs.start) begin
          do_load = 1'b1;
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      py_d    = RstPy;
      m1x_d   = RstM1x;
      m1y_d   = RstM1y;
      m2x_d   = RstM2x;
      m2y_d   = RstM2y;
      lx_d    = RstLx;
      ly_d    = RstLy;
      score_d = '0;
    end else if (do_update) begin
      py_d    = up_py;
      m1x_d   = up_m1x;
      m1y_d   = up_m1y;
      m2x_d   = up_m2x;
      m2y_d   = up_m2y;
      lx_d    = up_lx;
      ly_d    = up_ly;
      score_d = up_score;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      py_q    <= RstPy;
      m1x_q   <= RstM1x;
      m1y_q   <= RstM1y;
      m2x_q   <= RstM2x;
      m2y_q   <= RstM2y;
      lx_q    <= RstLx;
      ly_q    <= RstLy;
      score_q <= '0;
      lfsr_q  <= RstLfsr;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      py_q    <= py_d;
      m1x_q   <= m1x_d;
      m1y_q   <= m1y_d;
      m2x_q   <= m2x_d;
      m2y_q   <= m2y_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      chk_q   <= chk_d;
    end
  end

  assign gs.plane_y     = py_q;
  assign gs.mountain1_x = m1x_q;
  assign gs.mountain1_y = m1y_q;
  assign gs.mountain2_x = m2x_q;
  assign gs.mountain2_y = m2y_q;
  assign gs.lava_x      = lx_q;
  assign gs.lava_y      = ly_q;
  assign gs.score       = score_q;
  assign gs.game_over   = (state_q == StOver);

endmodule

// File: tb/tb_game_state_engine.sv
// Self-checking bench for game_state_engine: a behavioural game model predicts
// every frame, expected snapshots go into a queue when a frame_tick is driven
// and are popped and compared after the update edge and the collision edge.
module tb_game_state_engine;

  typedef struct packed {
    logic [9:0] py, m1x, m1y, m2x, m2y, lx, ly;
    logic [7:0] score;
    logic       over;
  } snap_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  game_state_engine_if gs_if ();

  game_state_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .gs     (gs_if)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t exp_q[$];

  // Behavioural model; m_state: 0 idle, 1 play, 2 over.
  int          m_py, m_m1x, m_m1y, m_m2x, m_m2y, m_lx, m_ly, m_score, m_state;
  logic [15:0] lfsr_m;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_m <= 16'hACE1;
    else lfsr_m <= (lfsr_m >> 1) | (16'(((lfsr_m >> 0) ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^
                                         (lfsr_m >> 5)) & 16'd1) << 15);
  end

  function automatic snap_t reset_snap();
    snap_t s;
    s.py = 10'd200; s.m1x = 10'd640; s.m1y = 10'd300; s.m2x = 10'd960; s.m2y = 10'd350;
    s.lx = 10'd647; s.ly = 10'd284; s.score = 8'd0; s.over = 1'b0;
    return s;
  endfunction

  function automatic snap_t model_snap(input bit over);
    snap_t s;
    s.py = 10'(m_py); s.m1x = 10'(m_m1x); s.m1y = 10'(m_m1y); s.m2x = 10'(m_m2x);
    s.m2y = 10'(m_m2y); s.lx = 10'(m_lx); s.ly = 10'(m_ly); s.score = 8'(m_score);
    s.over = over;
    return s;
  endfunction

  function automatic snap_t get_obs();
    snap_t s;
    s.py = gs_if.plane_y; s.m1x = gs_if.mountain1_x; s.m1y = gs_if.mountain1_y;
    s.m2x = gs_if.mountain2_x; s.m2y = gs_if.mountain2_y; s.lx = gs_if.lava_x;
    s.ly = gs_if.lava_y; s.score = gs_if.score; s.over = gs_if.game_over;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("py=%0d m1=(%0d,%0d) m2=(%0d,%0d) lava=(%0d,%0d) score=%0d over=%0b",
                     s.py, s.m1x, s.m1y, s.m2x, s.m2y, s.lx, s.ly, s.score, s.over);
  endfunction

  function automatic bit ovl(input int a0, input int a1, input int b0, input int b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  task automatic model_reset();
    m_py = 200; m_m1x = 640; m_m1y = 300; m_m2x = 960; m_m2y = 350;
    m_lx = 647; m_ly = 284; m_score = 0;
  endtask

  task automatic model_tick(input logic f);
    bit w1, w2, hit;
    if (m_state != 1) begin
      exp_q.push_back(model_snap(m_state == 2));
      exp_q.push_back(model_snap(m_state == 2));
    end else begin
      if (f) m_py = (m_py < 3) ? 0 : m_py - 3;
      else   m_py = (m_py + 2 > 463) ? 463 : m_py + 2;
      w1 = m_m1x < 2;
      w2 = m_m2x < 2;
      if (w1) begin m_m1x += 638; m_m1y = 240 + int'(lfsr_m % 128); end
      else m_m1x -= 2;
      if (w2) begin m_m2x += 638; m_m2y = 240 + int'(lfsr_m % 128); end
      else m_m2x -= 2;
      m_score += int'(w1) + int'(w2);
      if (m_score > 255) m_score = 255;
      m_lx = m_m1x + 7;
      if (w1 || m_ly < 4) m_ly = m_m1y - 16;
      else m_ly -= 4;
      exp_q.push_back(model_snap(1'b0));
      hit = (m_py == 463) ||
            (ovl(100, 116, m_m1x, m_m1x + 30) && ovl(m_py, m_py + 16, m_m1y, 479)) ||
            (ovl(100, 116, m_m2x, m_m2x + 30) && ovl(m_py, m_py + 16, m_m2y, 479)) ||
            (ovl(100, 116, m_lx, m_lx + 16) && ovl(m_py, m_py + 16, m_ly, m_ly + 16));
      if (hit) m_state = 2;
      exp_q.push_back(model_snap(hit));
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the tick edge.
  task automatic drive_tick(input logic f);
    gs_if.flap       = f;
    gs_if.frame_tick = 1'b1;
    model_tick(f);
    @(negedge clk);
    gs_if.frame_tick = 1'b0;
  endtask

  task automatic press_start();
    gs_if.start = 1'b1;
    if (m_state != 1) begin
      model_reset();
      m_state = 1;
    end
    @(negedge clk);
    gs_if.start = 1'b0;
  endtask

  task automatic test_reset();
    snap_t e, o;
    o = get_obs();
    n_checks++;
    if (o !== reset_snap()) begin
      n_fail++;
      $display("FAIL reset_values: got %s, expected %s", fmt(o), fmt(reset_snap()));
    end
    // Ticks are ignored while idle.
    drive_tick(1'b0);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_tick: got %s, expected %s", fmt(o), fmt(e));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_first_ticks();
    snap_t e, o;
    press_start();
    o = get_obs(); n_checks++;
    if (o !== reset_snap()) begin
      n_fail++;
      $display("FAIL start_from_idle: got %s, expected %s", fmt(o), fmt(reset_snap()));
    end
    for (int t = 0; t < 10; t++) begin
      drive_tick(1'b0);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL first_ticks t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
    o = get_obs(); n_checks++;
    if (o.py !== 10'd220 || o.m1x !== 10'd620 || o.m2x !== 10'd940 || o.ly !== 10'd244 ||
        o.lx !== 10'd627 || o.over !== 1'b0) begin
      n_fail++;
      $display("FAIL ten_ticks_fixed: got %s, expected py=220 m1x=620 m2x=940 lava=(627,244)",
               fmt(o));
    end
  endtask

  task automatic test_floor_clamp();
    snap_t e, o;
    for (int t = 0; t < 300 && m_state == 1; t++) begin
      drive_tick(1'b0);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL floor_fall t%0d/%0d: got %s, expected %s", t, k, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
    o = get_obs(); n_checks++;
    if (o.py !== 10'd463 || o.over !== 1'b1) begin
      n_fail++;
      $display("FAIL floor_over: got py=%0d over=%0b, expected py=463 over=1", o.py, o.over);
    end
    // Frozen in OVER.
    for (int t = 0; t < 4; t++) begin
      drive_tick(t[0]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL over_frozen t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_restart_and_ceiling();
    snap_t e, o;
    press_start();
    o = get_obs(); n_checks++;
    if (o !== reset_snap()) begin
      n_fail++;
      $display("FAIL restart_reload: got %s, expected %s", fmt(o), fmt(reset_snap()));
    end
    for (int t = 0; t < 71; t++) begin
      drive_tick(1'b1);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL climb t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
    o = get_obs(); n_checks++;
    if (o.py !== 10'd0 || o.over !== 1'b0) begin
      n_fail++;
      $display("FAIL ceiling_clamp: got py=%0d over=%0b, expected py=0 over=0", o.py, o.over);
    end
  endtask

  task automatic test_mountain_wrap();
    snap_t e, o;
    int    extra;
    extra = 0;
    for (int t = 0; t < 400 && extra < 5; t++) begin
      if (m_score != 0) extra++;
      drive_tick(m_py > 200);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL wrap_run t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
    o = get_obs(); n_checks++;
    if (o.score !== 8'd1 || o.m1y < 10'd240 || o.m1y > 10'd367 || o.over !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_score: got score=%0d m1y=%0d over=%0b, expected score=1 m1y 240..367",
               o.score, o.m1y, o.over);
    end
  endtask

  task automatic test_reset_mid_play();
    snap_t e, o;
    #2 resetn = 1'b0;
    #1 o = get_obs();
    n_checks++;
    if (o !== reset_snap()) begin
      n_fail++;
      $display("FAIL async_reset: got %s, expected %s", fmt(o), fmt(reset_snap()));
    end
    model_reset();
    m_state = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    drive_tick(1'b1);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_after_reset: got %s, expected %s", fmt(o), fmt(e));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mountain_hit();
    snap_t e, o;
    press_start();
    for (int t = 0; t < 400 && m_state == 1; t++) begin
      drive_tick(m_py > 290);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL hit_run t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
    o = get_obs(); n_checks++;
    if (o.over !== 1'b1 || o.m1x !== 10'd116 || o.score !== 8'd0) begin
      n_fail++;
      $display("FAIL mountain_hit: got over=%0b m1x=%0d score=%0d, expected over=1 m1x=116 0",
               o.over, o.m1x, o.score);
    end
    for (int t = 0; t < 3; t++) begin
      drive_tick(1'b0);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = get_obs(); n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL hit_frozen t%0d: got %s, expected %s", t, fmt(o), fmt(e));
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn           = 1'b0;
    gs_if.frame_tick = 1'b0;
    gs_if.flap       = 1'b0;
    gs_if.start      = 1'b0;
    model_reset();
    m_state = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_ticks();
    test_floor_clamp();
    test_restart_and_ceiling();
    test_mountain_wrap();
    test_reset_mid_play();
    test_mountain_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
